aggregator_flex: RTL

//   Narrow-to-wide packer, successor to the fixed-ratio aggregator. Dequeues DATA_WIDTH words

---
 rtl/aggregator_flex.sv | 111 +++++++++++
 1 files changed

// File: rtl/aggregator_flex.sv
`default_nettype none
// ============================================================================
// Module   : aggregator_flex
// Purpose  : packs DATA_WIDTH sender words into beats of up to FETCH_WIDTH lanes
// Revision : 1.0
// ============================================================================
module aggregator_flex #(
  parameter int DATA_WIDTH     = 8,
  parameter int FETCH_WIDTH    = 4,
  parameter int BEAT_CNT_WIDTH = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [$clog2(FETCH_WIDTH):0]      cfg_count,
  input  logic                              flush,
  input  logic [DATA_WIDTH-1:0]             sender_data,
  input  logic                              sender_empty_n,
  output logic                              sender_deq,
  output logic [FETCH_WIDTH*DATA_WIDTH-1:0] receiver_data,
  output logic [FETCH_WIDTH-1:0]            receiver_mask,
  input  logic                              receiver_full_n,
  output logic                              receiver_enq,
  output logic                              busy,
  output logic [BEAT_CNT_WIDTH-1:0]         beat_count
);

  localparam int                c_CNT_W = $clog2(FETCH_WIDTH) + 1;
  localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(FETCH_WIDTH);
  localparam logic [c_CNT_W-1:0] c_ONE  = c_CNT_W'(1);

  logic [DATA_WIDTH-1:0]             r_pack [FETCH_WIDTH];
  logic [c_CNT_W-1:0]                r_cnt;
  logic [c_CNT_W-1:0]                r_n_lat;
  logic [FETCH_WIDTH*DATA_WIDTH-1:0] r_out_data;
  logic [FETCH_WIDTH-1:0]            r_out_mask;
  logic                              r_out_valid;
  logic                              r_flush_pend;
  logic [BEAT_CNT_WIDTH-1:0]         r_beat_count;

  logic [c_CNT_W-1:0]                w_cfg_n;
  logic                              w_enq;
  logic                              w_out_free;
  logic                              w_move;
  logic                              w_deq;
  logic [c_CNT_W-1:0]                w_lane;
  logic [FETCH_WIDTH*DATA_WIDTH-1:0] w_beat_data;
  logic [FETCH_WIDTH-1:0]            w_beat_mask;

  always_comb begin
    w_cfg_n = cfg_count;
    if (cfg_count == '0 || cfg_count > c_FULL) w_cfg_n = c_FULL;
  end

  // Reset suppresses both handshakes so no word or beat is lost while it is held.
  assign w_enq      = r_out_valid && receiver_full_n && !rst;
  assign w_out_free = !r_out_valid || w_enq;
  assign w_move     = w_out_free && (r_cnt == r_n_lat || (r_flush_pend && r_cnt != '0));
  assign w_deq      = sender_empty_n && !r_flush_pend && !rst && (r_cnt < r_n_lat || w_move);
  assign w_lane     = w_move ? '0 : r_cnt;

  always_comb begin
    w_beat_mask = '0;
    w_beat_data = '0;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      w_beat_mask[k] = (c_CNT_W'(k) < r_cnt);
      if (c_CNT_W'(k) < r_cnt) w_beat_data[k*DATA_WIDTH +: DATA_WIDTH] = r_pack[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= '0;
      r_n_lat      <= c_FULL;
      r_out_data   <= '0;
      r_out_mask   <= '0;
      r_out_valid  <= 1'b0;
      r_flush_pend <= 1'b0;
      r_beat_count <= '0;
    end else begin
      if (r_cnt == '0 && !w_deq) r_n_lat <= w_cfg_n;
      if (w_move) begin
        r_out_data   <= w_beat_data;
        r_out_mask   <= w_beat_mask;
        r_out_valid  <= 1'b1;
        r_cnt        <= w_deq ? c_ONE : '0;
        r_beat_count <= r_beat_count + BEAT_CNT_WIDTH'(1);
      end else begin
        if (w_enq) r_out_valid <= 1'b0;
        if (w_deq) r_cnt <= r_cnt + c_ONE;
      end
      // A pending flush with nothing packed retires without producing an empty beat.
      r_flush_pend <= (flush || r_flush_pend) && !w_move && !(r_flush_pend && r_cnt == '0);
    end
  end

  // Lanes at or above cnt are never exposed, so the pack needs no reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      if (w_deq && w_lane == c_CNT_W'(k)) r_pack[k] <= sender_data;
    end
  end

  assign sender_deq    = w_deq;
  assign receiver_enq  = w_enq;
  assign receiver_data = r_out_data;
  assign receiver_mask = r_out_mask;
  assign busy          = (r_cnt != '0) || r_out_valid || r_flush_pend;
  assign beat_count    = r_beat_count;

endmodule
`default_nettype wire
